uart_regif: RTL and testbench
=============================

Name: uart_regif

Overview:
- Register bank for the APB UART, one stage downstream of the APB-to-memory bridge.
- Consumes single-cycle memory requests (mreq/maddr/mwe/mwdata/mstrb) and returns mack/mrdata/mresp exactly one cycle later.
- Holds control and baud configuration, pushes TX bytes into the TX FIFO, pops RX bytes from the RX FIFO, and aggregates interrupts.

Parameters:
ADDR_WIDTH, 32, memory address width; full address decoded, map at offset 0.
DATA_WIDTH, 32, data width; only 32 supported.
CLK_DIV_RST, 868, reset value of CFG.clk_div.

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous reset, active low
mreq_i  in  1  request pulse, one cycle per transaction
maddr_i  in  ADDR_WIDTH  byte address
mwe_i  in  1  1=write, 0=read
mwdata_i  in  32  write data
mstrb_i  in  4  byte strobes
mack_o  out  1  response valid, one-cycle pulse
mrdata_o  out  32  read data, valid with mack_o
mresp_o  out  1  error, valid with mack_o
ctrl_o  out  5  {two_stop, parity_odd, parity_en, rx_en, tx_en}
clk_div_o  out  32  baud divider
tx_data_o  out  8  byte to TX FIFO
tx_push_o  out  1  TX FIFO push pulse
tx_full_i  in  1  TX FIFO full
tx_empty_i  in  1  TX FIFO empty
rx_data_i  in  8  RX FIFO head (show-ahead)
rx_pop_o  out  1  RX FIFO pop pulse
rx_empty_i  in  1  RX FIFO empty
rx_full_i  in  1  RX FIFO full
rx_overrun_i  in  1  overrun event pulse
irq_o  out  1  interrupt, registered

Behaviour:
- Reset: mack_o=0, mrdata_o=0, mresp_o=0, ctrl_o=0, clk_div_o=CLK_DIV_RST, tx_push_o=0, rx_pop_o=0, tx_data_o=0, overrun=0, INT_EN=0, irq_o=0.
- Map:
  - 0x00 CTRL RW [4:0].
  - 0x04 CFG RW clk_div[31:0].
  - 0x08 STAT: read {27'b0, overrun, rx_empty, rx_full, tx_empty, tx_full}; write W1C on bit 4 only.
  - 0x0C TXD WO [7:0].
  - 0x10 RXD RO [7:0].
  - 0x14 INT_EN RW [2:0] = {overrun, rx_not_empty, tx_empty}.
- Decode and side effects are evaluated in the mreq_i cycle. Response is registered: mack_o=1 in cycle N+1 for mreq_i in cycle N; mack_o=0 otherwise. mrdata_o=0 whenever mack_o=0 or mresp_o=1.
- Back-to-back mreq_i (cycle N and N+1) each get their own ack (N+1, N+2).
- Error (mresp_o=1, no side effect): maddr_i[1:0]!=0; unmapped address; write to RXD; read of TXD.
- RW registers update per strobed byte; unused bits read 0. mstrb_i=0 write: no change, no error.
- TXD write:
  - tx_full_i=1 or mstrb_i[0]=0: mresp_o=1, no push.
  - Otherwise tx_push_o=1 and tx_data_o=mwdata_i[7:0] in cycle N+1 only.
- RXD read:
  - rx_empty_i=1: mresp_o=1, mrdata_o=0, no pop.
  - Otherwise mrdata_o={24'b0, rx_data_i sampled cycle N} and rx_pop_o=1 in cycle N+1.
- overrun sticky flag:
  - Set by rx_overrun_i.
  - Cleared by STAT write with mstrb_i[0]=1 and mwdata_i[4]=1.
  - Set and clear in the same cycle: set wins.
- irq_o registered = |(INT_EN & {overrun, ~rx_empty_i, tx_empty_i}); one cycle latency.
- Async reset mid-transaction drops the pending ack and push/pop pulses immediately.

Optional Feature:
- UART_REGIF_SCRATCH_EN defined: 0x18 SCRATCH RW 32-bit, reset 0, per-byte strobes, no side effects.
- Undefined: 0x18 is unmapped and returns mresp_o=1.

Test Plan:
- Write CTRL 0x1B with strb 0xF, read back -> ack 1 cycle after each req, mrdata=0x1B, ctrl_o=0x1B, mresp=0.
- Write CFG 0xAABBCCDD with strb 0x2 -> clk_div_o=0x0000CC64 (from reset 0x364), mresp=0.
- TXD write 0x5A with tx_full_i=0 -> tx_push_o pulse with tx_data_o=0x5A aligned with mack. Repeat with tx_full_i=1 -> mresp=1, no push.
- RXD read with rx_data_i=0x3C, rx_empty_i=0 -> mrdata=0x3C, rx_pop_o pulse. Repeat with rx_empty_i=1 -> mresp=1, mrdata=0, no pop.
- rx_overrun_i pulse, INT_EN=0x4 -> STAT[4]=1, irq_o=1 next cycle. STAT write 0x10 coincident with a new rx_overrun_i -> flag stays 1. Later STAT write 0x10 -> flag 0, irq_o=0.
- Accesses to 0x02, 0x1C, a TXD read, and an RXD write -> each mresp=1 with no register change. 0x18 errors unless UART_REGIF_SCRATCH_EN is defined, in which case 0x18 read/write succeeds.

Source files
------------

// File: rtl/uart_regif.sv
// ---------------------------------------------------------------------------
// uart_regif -- register bank for the APB UART.
//
// Sits one stage behind the APB-to-memory bridge. It takes single-cycle
// memory requests and answers each one exactly one cycle later with
// mack_o/mrdata_o/mresp_o. It holds the control and baud configuration,
// pushes bytes into the TX FIFO, pops bytes from the RX FIFO, and combines
// the interrupt sources into irq_o.
//
// Register map (byte offsets, full address decode, word aligned):
//   0x00 CTRL    RW [4:0] {two_stop, parity_odd, parity_en, rx_en, tx_en}
//   0x04 CFG     RW clk_div[31:0]
//   0x08 STAT    R  {overrun, rx_empty, rx_full, tx_empty, tx_full}
//                W  bit 4 write-one-to-clear (overrun)
//   0x0C TXD     WO [7:0]  push into TX FIFO
//   0x10 RXD     RO [7:0]  pop from RX FIFO
//   0x14 INT_EN  RW [2:0] {overrun, rx_not_empty, tx_empty}
//   0x18 SCRATCH RW 32-bit, present only when UART_REGIF_SCRATCH_EN is defined
//
// Ports:
//   clk_i, arst_ni                 clock, asynchronous active-low reset
//   mreq_i/maddr_i/mwe_i/
//   mwdata_i/mstrb_i               memory request (one cycle per transaction)
//   mack_o/mrdata_o/mresp_o        response, registered, one cycle after mreq_i
//   ctrl_o, clk_div_o              configuration outputs
//   tx_data_o/tx_push_o,
//   tx_full_i/tx_empty_i           TX FIFO interface
//   rx_data_i/rx_pop_o,
//   rx_empty_i/rx_full_i           RX FIFO interface (show-ahead head)
//   rx_overrun_i                   overrun event pulse
//   irq_o                          registered interrupt
// ---------------------------------------------------------------------------
module uart_regif #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] CLK_DIV_RST = 32'd868
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  mreq_i,
  input  logic [ADDR_WIDTH-1:0] maddr_i,
  input  logic                  mwe_i,
  input  logic [DATA_WIDTH-1:0] mwdata_i,
  input  logic [3:0]            mstrb_i,
  output logic                  mack_o,
  output logic [DATA_WIDTH-1:0] mrdata_o,
  output logic                  mresp_o,
  output logic [4:0]            ctrl_o,
  output logic [31:0]           clk_div_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_push_o,
  input  logic                  tx_full_i,
  input  logic                  tx_empty_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_pop_o,
  input  logic                  rx_empty_i,
  input  logic                  rx_full_i,
  input  logic                  rx_overrun_i,
  output logic                  irq_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CFG     = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STAT    = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TXD     = ADDR_WIDTH'(32'h0C);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RXD     = ADDR_WIDTH'(32'h10);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INT_EN  = ADDR_WIDTH'(32'h14);
`ifdef UART_REGIF_SCRATCH_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_SCRATCH = ADDR_WIDTH'(32'h18);
`endif

  // Replace each strobed byte of the old value with the matching write byte.
  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  logic        mack_q,    mack_d;
  logic [31:0] mrdata_q,  mrdata_d;
  logic        mresp_q,   mresp_d;
  logic [4:0]  ctrl_q,    ctrl_d;
  logic [31:0] clk_div_q, clk_div_d;
  logic [2:0]  int_en_q,  int_en_d;
  logic        overrun_q, overrun_d;
  logic        irq_q,     irq_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_push_q, tx_push_d;
  logic        rx_pop_q,  rx_pop_d;
`ifdef UART_REGIF_SCRATCH_EN
  logic [31:0] scratch_q, scratch_d;
`endif

  logic        ovr_clr;
  logic [31:0] merged;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    mack_d    = mreq_i;
    mrdata_d  = '0;
    mresp_d   = 1'b0;
    ctrl_d    = ctrl_q;
    clk_div_d = clk_div_q;
    int_en_d  = int_en_q;
    tx_data_d = '0;
    tx_push_d = 1'b0;
    rx_pop_d  = 1'b0;
    ovr_clr   = 1'b0;
    merged    = '0;
`ifdef UART_REGIF_SCRATCH_EN
    scratch_d = scratch_q;
`endif

    if (mreq_i) begin
      // Offsets are all word aligned, so a misaligned address falls through
      // to the default arm and errors without side effects.
      case (maddr_i)
        ADDR_CTRL: begin
          merged = merge_strb({27'b0, ctrl_q}, mwdata_i, mstrb_i);
          if (mwe_i) ctrl_d = merged[4:0];
          else       mrdata_d = {27'b0, ctrl_q};
        end
        ADDR_CFG: begin
          merged = merge_strb(clk_div_q, mwdata_i, mstrb_i);
          if (mwe_i) clk_div_d = merged;
          else       mrdata_d  = clk_div_q;
        end
        ADDR_STAT: begin
          if (mwe_i) ovr_clr  = mstrb_i[0] & mwdata_i[4];
          else       mrdata_d = {27'b0, overrun_q, rx_empty_i, rx_full_i,
                                 tx_empty_i, tx_full_i};
        end
        ADDR_TXD: begin
          if (!mwe_i || tx_full_i || !mstrb_i[0]) begin
            mresp_d = 1'b1;
          end else begin
            tx_push_d = 1'b1;
            tx_data_d = mwdata_i[7:0];
          end
        end
        ADDR_RXD: begin
          if (mwe_i || rx_empty_i) begin
            mresp_d = 1'b1;
          end else begin
            rx_pop_d = 1'b1;
            mrdata_d = {24'b0, rx_data_i};
          end
        end
        ADDR_INT_EN: begin
          merged = merge_strb({29'b0, int_en_q}, mwdata_i, mstrb_i);
          if (mwe_i) int_en_d = merged[2:0];
          else       mrdata_d = {29'b0, int_en_q};
        end
`ifdef UART_REGIF_SCRATCH_EN
        ADDR_SCRATCH: begin
          merged = merge_strb(scratch_q, mwdata_i, mstrb_i);
          if (mwe_i) scratch_d = merged;
          else       mrdata_d  = scratch_q;
        end
`endif
        default: mresp_d = 1'b1;
      endcase
    end

    // A new overrun event in the same cycle as a clear keeps the flag set.
    overrun_d = rx_overrun_i | (overrun_q & ~ovr_clr);
    irq_d     = |(int_en_q & {overrun_q, ~rx_empty_i, tx_empty_i});
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      mack_q    <= 1'b0;
      mrdata_q  <= '0;
      mresp_q   <= 1'b0;
      ctrl_q    <= '0;
      clk_div_q <= CLK_DIV_RST;
      int_en_q  <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
      tx_data_q <= '0;
      tx_push_q <= 1'b0;
      rx_pop_q  <= 1'b0;
`ifdef UART_REGIF_SCRATCH_EN
      scratch_q <= '0;
`endif
    end else begin
      mack_q    <= mack_d;
      mrdata_q  <= mrdata_d;
      mresp_q   <= mresp_d;
      ctrl_q    <= ctrl_d;
      clk_div_q <= clk_div_d;
      int_en_q  <= int_en_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
      tx_data_q <= tx_data_d;
      tx_push_q <= tx_push_d;
      rx_pop_q  <= rx_pop_d;
`ifdef UART_REGIF_SCRATCH_EN
      scratch_q <= scratch_d;
`endif
    end
  end

  assign mack_o    = mack_q;
  assign mrdata_o  = mrdata_q;
  assign mresp_o   = mresp_q;
  assign ctrl_o    = ctrl_q;
  assign clk_div_o = clk_div_q;
  assign tx_data_o = tx_data_q;
  assign tx_push_o = tx_push_q;
  assign rx_pop_o  = rx_pop_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_uart_regif.sv
// ---------------------------------------------------------------------------
// tb_uart_regif -- directed self-checking bench for uart_regif.
// Each scenario task drives one or more memory transactions and compares the
// registered response and side outputs against hand-computed values.
// Define UART_REGIF_SCRATCH_EN for both files to exercise the scratch register.
// ---------------------------------------------------------------------------
module tb_uart_regif;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        mreq_i;
  logic [31:0] maddr_i;
  logic        mwe_i;
  logic [31:0] mwdata_i;
  logic [3:0]  mstrb_i;
  logic        mack_o;
  logic [31:0] mrdata_o;
  logic        mresp_o;
  logic [4:0]  ctrl_o;
  logic [31:0] clk_div_o;
  logic [7:0]  tx_data_o;
  logic        tx_push_o;
  logic        tx_full_i;
  logic        tx_empty_i;
  logic [7:0]  rx_data_i;
  logic        rx_pop_o;
  logic        rx_empty_i;
  logic        rx_full_i;
  logic        rx_overrun_i;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Captured response of the last transaction.
  logic        r_ack, r_resp, r_push, r_pop;
  logic [31:0] r_rdata;
  logic [7:0]  r_txd;

  uart_regif dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .mreq_i      (mreq_i),
    .maddr_i     (maddr_i),
    .mwe_i       (mwe_i),
    .mwdata_i    (mwdata_i),
    .mstrb_i     (mstrb_i),
    .mack_o      (mack_o),
    .mrdata_o    (mrdata_o),
    .mresp_o     (mresp_o),
    .ctrl_o      (ctrl_o),
    .clk_div_o   (clk_div_o),
    .tx_data_o   (tx_data_o),
    .tx_push_o   (tx_push_o),
    .tx_full_i   (tx_full_i),
    .tx_empty_i  (tx_empty_i),
    .rx_data_i   (rx_data_i),
    .rx_pop_o    (rx_pop_o),
    .rx_empty_i  (rx_empty_i),
    .rx_full_i   (rx_full_i),
    .rx_overrun_i(rx_overrun_i),
    .irq_o       (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // One transaction: request held for one cycle (driven 1ns after an edge),
  // response sampled 1ns after the following edge.
  task automatic bus(input logic [31:0] addr, input logic we,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input logic ovr);
    @(posedge clk_i); #1;
    mreq_i = 1'b1; maddr_i = addr; mwe_i = we; mwdata_i = wdata;
    mstrb_i = strb; rx_overrun_i = ovr;
    if (mack_o !== 1'b0) begin
      n_bad++; $display("FAIL ack_early: got %0b want 0", mack_o);
    end
    n_cmp++;
    @(posedge clk_i); #1;
    mreq_i = 1'b0; mwe_i = 1'b0; mwdata_i = '0; mstrb_i = '0;
    rx_overrun_i = 1'b0;
    r_ack = mack_o; r_rdata = mrdata_o; r_resp = mresp_o;
    r_push = tx_push_o; r_txd = tx_data_o; r_pop = rx_pop_o;
    n_cmp++;
    if (r_ack !== 1'b1) begin
      n_bad++; $display("FAIL ack_n1 @%h: got %0b want 1", addr, r_ack);
    end
  endtask

  task automatic test_reset();
    arst_ni = 1'b0;
    mreq_i = 0; maddr_i = 0; mwe_i = 0; mwdata_i = 0; mstrb_i = 0;
    tx_full_i = 0; tx_empty_i = 0; rx_data_i = 0; rx_empty_i = 1;
    rx_full_i = 0; rx_overrun_i = 0;
    #12;
    n_cmp++;
    if ({mack_o, mresp_o, tx_push_o, rx_pop_o, irq_o} !== 5'b0) begin
      n_bad++; $display("FAIL rst_pulses: got %b want 00000",
                        {mack_o, mresp_o, tx_push_o, rx_pop_o, irq_o});
    end
    n_cmp++;
    if (mrdata_o !== 32'h0 || tx_data_o !== 8'h0 || ctrl_o !== 5'h0) begin
      n_bad++; $display("FAIL rst_data: rdata %h txd %h ctrl %h want 0",
                        mrdata_o, tx_data_o, ctrl_o);
    end
    n_cmp++;
    if (clk_div_o !== 32'd868) begin
      n_bad++; $display("FAIL rst_clk_div: got %h want 364", clk_div_o);
    end
    @(negedge clk_i); arst_ni = 1'b1;
    bus(32'h14, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_rdata !== 32'h0 || r_resp !== 1'b0) begin
      n_bad++; $display("FAIL rst_int_en: got %h resp %0b want 0", r_rdata, r_resp);
    end
    bus(32'h08, 0, 0, 4'h0, 0);
    n_cmp++;
    // overrun=0, rx_empty=1, rx_full=0, tx_empty=0, tx_full=0
    if (r_rdata !== 32'h08) begin
      n_bad++; $display("FAIL rst_stat: got %h want 00000008", r_rdata);
    end
  endtask

  task automatic test_ctrl();
    bus(32'h00, 1, 32'h1B, 4'hF, 0);
    n_cmp++;
    if (r_resp !== 1'b0 || r_rdata !== 32'h0 || ctrl_o !== 5'h1B) begin
      n_bad++; $display("FAIL ctrl_wr: resp %0b rdata %h ctrl %h want 0/0/1b",
                        r_resp, r_rdata, ctrl_o);
    end
    bus(32'h00, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_rdata !== 32'h1B || r_resp !== 1'b0) begin
      n_bad++; $display("FAIL ctrl_rd: got %h resp %0b want 1b/0", r_rdata, r_resp);
    end
    bus(32'h00, 1, 32'hFFFF_FFFF, 4'h0, 0);
    n_cmp++;
    if (r_resp !== 1'b0 || ctrl_o !== 5'h1B) begin
      n_bad++; $display("FAIL ctrl_strb0: resp %0b ctrl %h want 0/1b", r_resp, ctrl_o);
    end
    bus(32'h00, 1, 32'hFFFF_FFFF, 4'h1, 0);
    bus(32'h00, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_rdata !== 32'h1F) begin
      n_bad++; $display("FAIL ctrl_unused: got %h want 0000001f", r_rdata);
    end
  endtask

  task automatic test_cfg();
    bus(32'h04, 1, 32'hAABB_CCDD, 4'h2, 0);
    n_cmp++;
    if (clk_div_o !== 32'h0000_CC64 || r_resp !== 1'b0) begin
      n_bad++; $display("FAIL cfg_strb: got %h resp %0b want 0000cc64/0",
                        clk_div_o, r_resp);
    end
    bus(32'h04, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_rdata !== 32'h0000_CC64) begin
      n_bad++; $display("FAIL cfg_rd: got %h want 0000cc64", r_rdata);
    end
  endtask

  task automatic test_tx();
    tx_full_i = 0;
    bus(32'h0C, 1, 32'h0000_005A, 4'h1, 0);
    n_cmp++;
    if (r_push !== 1'b1 || r_txd !== 8'h5A || r_resp !== 1'b0) begin
      n_bad++; $display("FAIL tx_push: push %0b data %h resp %0b want 1/5a/0",
                        r_push, r_txd, r_resp);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if (tx_push_o !== 1'b0 || mack_o !== 1'b0) begin
      n_bad++; $display("FAIL tx_push_len: push %0b ack %0b want 0/0", tx_push_o, mack_o);
    end
    tx_full_i = 1;
    bus(32'h0C, 1, 32'h0000_005A, 4'h1, 0);
    n_cmp++;
    if (r_push !== 1'b0 || r_resp !== 1'b1) begin
      n_bad++; $display("FAIL tx_full: push %0b resp %0b want 0/1", r_push, r_resp);
    end
    tx_full_i = 0;
    bus(32'h0C, 1, 32'h0000_005A, 4'h2, 0);
    n_cmp++;
    if (r_push !== 1'b0 || r_resp !== 1'b1) begin
      n_bad++; $display("FAIL tx_nostrb0: push %0b resp %0b want 0/1", r_push, r_resp);
    end
  endtask

  task automatic test_rx();
    rx_data_i = 8'h3C; rx_empty_i = 0;
    bus(32'h10, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_rdata !== 32'h3C || r_pop !== 1'b1 || r_resp !== 1'b0) begin
      n_bad++; $display("FAIL rx_pop: rdata %h pop %0b resp %0b want 3c/1/0",
                        r_rdata, r_pop, r_resp);
    end
    rx_empty_i = 1;
    bus(32'h10, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_rdata !== 32'h0 || r_pop !== 1'b0 || r_resp !== 1'b1) begin
      n_bad++; $display("FAIL rx_empty: rdata %h pop %0b resp %0b want 0/0/1",
                        r_rdata, r_pop, r_resp);
    end
  endtask

  task automatic test_overrun();
    bus(32'h14, 1, 32'h4, 4'h1, 0);
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++; $display("FAIL irq_idle: got %0b want 0", irq_o);
    end
    @(posedge clk_i); #1 rx_overrun_i = 1;
    @(posedge clk_i); #1 rx_overrun_i = 0;
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++; $display("FAIL irq_latency: got %0b want 0", irq_o);
    end
    bus(32'h08, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_rdata !== 32'h18 || irq_o !== 1'b1) begin
      n_bad++; $display("FAIL ovr_set: stat %h irq %0b want 18/1", r_rdata, irq_o);
    end
    bus(32'h08, 1, 32'h10, 4'h1, 1);
    bus(32'h08, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_rdata[4] !== 1'b1 || irq_o !== 1'b1) begin
      n_bad++; $display("FAIL ovr_set_wins: flag %0b irq %0b want 1/1", r_rdata[4], irq_o);
    end
    bus(32'h08, 1, 32'h10, 4'h1, 0);
    bus(32'h08, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_rdata[4] !== 1'b0 || irq_o !== 1'b0) begin
      n_bad++; $display("FAIL ovr_clr: flag %0b irq %0b want 0/0", r_rdata[4], irq_o);
    end
    bus(32'h14, 1, 32'h0, 4'h1, 0);
  endtask

  task automatic test_errors();
    bus(32'h02, 1, 32'h0, 4'hF, 0);
    n_cmp++;
    if (r_resp !== 1'b1 || ctrl_o !== 5'h1F) begin
      n_bad++; $display("FAIL err_misalign: resp %0b ctrl %h want 1/1f", r_resp, ctrl_o);
    end
    bus(32'h1C, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_resp !== 1'b1 || r_rdata !== 32'h0) begin
      n_bad++; $display("FAIL err_unmapped: resp %0b rdata %h want 1/0", r_resp, r_rdata);
    end
    bus(32'h0C, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_resp !== 1'b1 || r_push !== 1'b0) begin
      n_bad++; $display("FAIL err_txd_rd: resp %0b push %0b want 1/0", r_resp, r_push);
    end
    rx_empty_i = 0; rx_data_i = 8'hA5;
    bus(32'h10, 1, 32'hFF, 4'hF, 0);
    n_cmp++;
    if (r_resp !== 1'b1 || r_pop !== 1'b0 || r_rdata !== 32'h0) begin
      n_bad++; $display("FAIL err_rxd_wr: resp %0b pop %0b rdata %h want 1/0/0",
                        r_resp, r_pop, r_rdata);
    end
    rx_empty_i = 1;
    bus(32'h0000_1000, 1, 32'h0, 4'hF, 0);
    n_cmp++;
    if (r_resp !== 1'b1 || ctrl_o !== 5'h1F || clk_div_o !== 32'h0000_CC64) begin
      n_bad++; $display("FAIL err_fulldecode: resp %0b ctrl %h div %h want 1/1f/cc64",
                        r_resp, ctrl_o, clk_div_o);
    end
`ifdef UART_REGIF_SCRATCH_EN
    bus(32'h18, 1, 32'h1234_5678, 4'hF, 0);
    bus(32'h18, 1, 32'hFFFF_FFFF, 4'h8, 0);
    bus(32'h18, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_resp !== 1'b0 || r_rdata !== 32'hFF34_5678) begin
      n_bad++; $display("FAIL scratch: resp %0b rdata %h want 0/ff345678", r_resp, r_rdata);
    end
`else
    bus(32'h18, 0, 0, 4'h0, 0);
    n_cmp++;
    if (r_resp !== 1'b1 || r_rdata !== 32'h0) begin
      n_bad++; $display("FAIL scratch_absent: resp %0b rdata %h want 1/0", r_resp, r_rdata);
    end
`endif
  endtask

  task automatic test_back_to_back();
    @(posedge clk_i); #1;
    mreq_i = 1; maddr_i = 32'h00; mwe_i = 1; mwdata_i = 32'h03; mstrb_i = 4'h1;
    @(posedge clk_i); #1;
    n_cmp++;
    if (mack_o !== 1'b1 || mresp_o !== 1'b0 || ctrl_o !== 5'h03) begin
      n_bad++; $display("FAIL b2b_first: ack %0b resp %0b ctrl %h want 1/0/03",
                        mack_o, mresp_o, ctrl_o);
    end
    mwe_i = 0; mwdata_i = 0; mstrb_i = 0;
    @(posedge clk_i); #1;
    mreq_i = 0;
    n_cmp++;
    if (mack_o !== 1'b1 || mrdata_o !== 32'h03) begin
      n_bad++; $display("FAIL b2b_second: ack %0b rdata %h want 1/03", mack_o, mrdata_o);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if (mack_o !== 1'b0 || mrdata_o !== 32'h0) begin
      n_bad++; $display("FAIL b2b_idle: ack %0b rdata %h want 0/0", mack_o, mrdata_o);
    end
  endtask

  task automatic test_async_reset();
    tx_full_i = 0;
    @(posedge clk_i); #1;
    mreq_i = 1; maddr_i = 32'h0C; mwe_i = 1; mwdata_i = 32'h77; mstrb_i = 4'h1;
    @(posedge clk_i); #1;
    mreq_i = 0; mwe_i = 0; mstrb_i = 0;
    n_cmp++;
    if (tx_push_o !== 1'b1 || mack_o !== 1'b1) begin
      n_bad++; $display("FAIL arst_pre: push %0b ack %0b want 1/1", tx_push_o, mack_o);
    end
    #1 arst_ni = 1'b0;
    #1;
    n_cmp++;
    if (tx_push_o !== 1'b0 || mack_o !== 1'b0 || tx_data_o !== 8'h0 ||
        ctrl_o !== 5'h0 || clk_div_o !== 32'd868) begin
      n_bad++; $display("FAIL arst_mid: push %0b ack %0b txd %h ctrl %h div %h",
                        tx_push_o, mack_o, tx_data_o, ctrl_o, clk_div_o);
    end
    @(negedge clk_i); arst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_cfg();
    test_tx();
    test_rx();
    test_overrun();
    test_errors();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
